// File: rtl/unison_readout_capture.sv
// unison_readout_capture
// ----------------------------------------------------------------------------
// Captures the logic-analyzer readout lanes of one digital_unison instance.
// Each enabled clk_master cycle samples {read_out_I, read_out_Q} as one nibble.
// Nibbles are packed LSB-first into WORD_W-bit words. Each word is buffered
// in a first-word-fall-through FIFO that firmware drains at its own pace.
//
// Parameters:
//   WORD_W : packed word width (multiple of 4, >= 8); NIB = WORD_W/4 samples
//   DEPTH  : FIFO depth in words (power of 2, >= 2); AW = $clog2(DEPTH)
//
// Ports:
//   clk_master  in  1        sole clock, rising edge
//   rstb        in  1        asynchronous active-low reset
//   cap_en      in  1        level capture enable
//   read_out_I  in  2        I-lane readout (nibble bits [3:2])
//   read_out_Q  in  2        Q-lane readout (nibble bits [1:0])
//   rd_en       in  1        pop request (ignored while empty)
//   rd_data     out WORD_W   FIFO head word, 0 while rd_valid=0
//   rd_valid    out 1        FIFO non-empty
//   fifo_count  out AW+1     words stored, 0..DEPTH
//   overflow    out 1        sticky: a completed word was dropped
//   clr_ovf     in  1        synchronous clear of overflow (set wins)
//
// Optional feature (macro READOUT_PARITY_EN):
//   Adds the output rd_parity. This bit is the XOR of the head word. It is
//   computed at push and stored next to the word in the FIFO. It reads 0
//   while the FIFO is empty.
// ----------------------------------------------------------------------------
module unison_readout_capture #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_master,
  input  logic              rstb,
  input  logic              cap_en,
  input  logic [1:0]        read_out_I,
  input  logic [1:0]        read_out_Q,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [AW:0]       fifo_count,
  output logic              overflow,
`ifdef READOUT_PARITY_EN
  output logic              rd_parity,
`endif
  input  logic              clr_ovf
);

  localparam int NIB   = WORD_W / 4;
  localparam int CW    = $clog2(NIB);
  localparam int CNT_W = AW + 1;
`ifdef READOUT_PARITY_EN
  localparam int MW    = WORD_W + 1;
`else
  localparam int MW    = WORD_W;
`endif

`ifdef READOUT_PARITY_EN
  // Even-parity helper: XOR of every bit of a packed word
  function automatic logic word_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction
`endif

  logic [3:0]        nib_s;
  logic [CW-1:0]     pack_cnt_r;
  logic [WORD_W-1:0] shift_r;
  logic [WORD_W-1:0] word_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic              wr_ok_s;
  logic              ovf_set_s;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              overflow_r;
  logic [MW-1:0]     mem_r [DEPTH];
  logic [MW-1:0]     entry_s;
  logic [MW-1:0]     head_s;

  assign nib_s = {read_out_I, read_out_Q};

  // Word being assembled, with the current nibble already merged in. The
  // push edge uses this so the final nibble lands in the stored word.
  always_comb begin
    word_s = shift_r;
    word_s[{pack_cnt_r, 2'b00} +: 4] = nib_s;
  end

  // FIFO control. Full and empty come from the count, never from the pointers.
  always_comb begin
    push_s    = cap_en && (pack_cnt_r == CW'(NIB - 1));
    full_s    = (count_r == CNT_W'(DEPTH));
    empty_s   = (count_r == {CNT_W{1'b0}});
    pop_s     = rd_en && !empty_s;
    // A full FIFO still accepts a word when a pop frees a slot on the same edge
    wr_ok_s   = push_s && (!full_s || pop_s);
    ovf_set_s = push_s && full_s && !pop_s;
  end

`ifdef READOUT_PARITY_EN
  // Storage entry: parity bit above the data word
  always_comb begin
    entry_s = {word_parity(word_s), word_s};
  end
`else
  // Storage entry: data word only
  always_comb begin
    entry_s = word_s;
  end
`endif

  // Pack counter and shift register. Dropping cap_en discards the partial word.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      pack_cnt_r <= {CW{1'b0}};
      shift_r    <= {WORD_W{1'b0}};
    end else if (!cap_en || push_s) begin
      pack_cnt_r <= {CW{1'b0}};
      shift_r    <= {WORD_W{1'b0}};
    end else begin
      pack_cnt_r <= pack_cnt_r + CW'(1);
      shift_r    <= word_s;
    end
  end

  // Write and read pointers, wrapping modulo DEPTH
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Fill level: pushes minus pops
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({wr_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow. A new drop on the same edge as clr_ovf keeps it set.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      overflow_r <= 1'b0;
    end else if (ovf_set_s) begin
      overflow_r <= 1'b1;
    end else if (clr_ovf) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // FIFO storage. It has no reset because reads are gated by rd_valid.
  always_ff @(posedge clk_master) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // First-word-fall-through head. It is forced to 0 while the FIFO is empty.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (!empty_s) begin
      rd_data = head_s[WORD_W-1:0];
    end else begin
      rd_data = {WORD_W{1'b0}};
    end
  end

`ifdef READOUT_PARITY_EN
  // Stored parity travels with the head word
  always_comb begin
    if (!empty_s) begin
      rd_parity = head_s[WORD_W];
    end else begin
      rd_parity = 1'b0;
    end
  end
`endif

  assign rd_valid   = !empty_s;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_unison_readout_capture.sv
// tb_unison_readout_capture
// ----------------------------------------------------------------------------
// Directed bench for unison_readout_capture (WORD_W=32, DEPTH=8).
// The bench's own packing model computes the expected words. These are
// queued when the final nibble is driven, then popped and compared when the
// bench reads them. Define READOUT_PARITY_EN to also check rd_parity.
// ----------------------------------------------------------------------------
module tb_unison_readout_capture;

  localparam int WORD_W = 32;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int NIB    = WORD_W / 4;

  logic              clk_master = 1'b0;
  logic              rstb       = 1'b0;
  logic              cap_en     = 1'b0;
  logic [1:0]        read_out_I = 2'b00;
  logic [1:0]        read_out_Q = 2'b00;
  logic              rd_en      = 1'b0;
  logic              clr_ovf    = 1'b0;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic [AW:0]       fifo_count;
  logic              overflow;
`ifdef READOUT_PARITY_EN
  logic              rd_parity;
`endif

  unison_readout_capture #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .clk_master (clk_master),
    .rstb       (rstb),
    .cap_en     (cap_en),
    .read_out_I (read_out_I),
    .read_out_Q (read_out_Q),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow),
`ifdef READOUT_PARITY_EN
    .rd_parity  (rd_parity),
`endif
    .clr_ovf    (clr_ovf)
  );

  always #5 clk_master = ~clk_master;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Reference model state
  logic [WORD_W-1:0] exp_q[$];
  int                m_idx  = 0;
  logic [WORD_W-1:0] m_word = '0;
  logic              m_ovf  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_idx  = 0;
    m_word = '0;
    m_ovf  = 1'b0;
  endtask

  // Drive one cycle's inputs and update the model. This also compares the
  // popped head before the edge and checks the status after it.
  task automatic cycle(input logic c, input logic [3:0] n, input logic r, input logic clr);
    logic pop, push, full_before;
    logic [WORD_W-1:0] pushed;
    cap_en     = c;
    read_out_I = n[3:2];
    read_out_Q = n[1:0];
    rd_en      = r;
    clr_ovf    = clr;
    full_before = (exp_q.size() == DEPTH);
    pop  = r && (exp_q.size() > 0);
    push = 1'b0;
    pushed = '0;
    if (pop) begin
      check("pop_data", rd_data, exp_q[0]);
`ifdef READOUT_PARITY_EN
      check("pop_parity", rd_parity, ^exp_q[0]);
`endif
      void'(exp_q.pop_front());
    end
    if (c) begin
      m_word[4*m_idx +: 4] = n;
      if (m_idx == NIB - 1) begin
        push   = 1'b1;
        pushed = m_word;
        m_idx  = 0;
        m_word = '0;
      end else begin
        m_idx++;
      end
    end else begin
      m_idx  = 0;
      m_word = '0;
    end
    if (push) begin
      if (!full_before || pop) exp_q.push_back(pushed);
      else m_ovf = 1'b1;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
    if (push && full_before && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk_master);
    #1;
    check("fifo_count", fifo_count, exp_q.size());
    check("rd_valid", rd_valid, exp_q.size() > 0);
    check("overflow", overflow, m_ovf);
    if (exp_q.size() == 0) check("rd_data_idle", rd_data, 0);
  endtask

  // Assert reset asynchronously mid-cycle, check the outputs, then release
  task automatic do_reset();
    rstb = 1'b0;
    #1;
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 1'b0);
    model_clear();
    cap_en = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    @(posedge clk_master);
    @(negedge clk_master);
    rstb = 1'b1;
  endtask

  task automatic drain_all();
    for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  initial begin
    // Initial reset and idle hold
    @(posedge clk_master); #2;
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0, 4'($urandom_range(15, 0)), 1'b0, 1'b0);

    // Packing order
    for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    check("pack_word", rd_data, 32'h8765_4321);
    check("pack_count", fifo_count, 1);
    drain_all();

    // Partial word discarded when cap_en drops
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'hA, 1'b0, 1'b0);
    cycle(1'b0, 4'hA, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'hF, 1'b0, 1'b0);
    check("partial_word", rd_data, 32'hFFFF_FFFF);
    check("partial_count", fifo_count, 1);
    drain_all();

    // Parity words 0x00000001 and 0x00000003
    for (int i = 0; i < 8; i++) cycle(1'b1, (i == 0) ? 4'h1 : 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, (i == 0) ? 4'h3 : 4'h0, 1'b0, 1'b0);
    check("par_word0", rd_data, 32'h0000_0001);
`ifdef READOUT_PARITY_EN
    check("par_bit0", rd_parity, 1'b1);
`endif
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    check("par_word1", rd_data, 32'h0000_0003);
`ifdef READOUT_PARITY_EN
    check("par_bit1", rd_parity, 1'b0);
`endif
    drain_all();

    // Overflow: 72 cycles of capture with no reads
    for (int i = 0; i < 72; i++) cycle(1'b1, 4'($urandom_range(15, 0)), 1'b0, 1'b0);
    check("ovf_count", fifo_count, 8);
    check("ovf_flag", overflow, 1'b1);
    // clr_ovf on the same edge as another drop: set wins
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'($urandom_range(15, 0)), 1'b0, i == 7);
    check("ovf_set_wins", overflow, 1'b1);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    check("ovf_cleared", overflow, 1'b0);
    drain_all();

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 64; i++) cycle(1'b1, 4'($urandom_range(15, 0)), 1'b0, 1'b0);
    check("full_count", fifo_count, 8);
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'($urandom_range(15, 0)), i == 7, 1'b0);
    check("full_pp_count", fifo_count, 8);
    check("full_pp_ovf", overflow, 1'b0);
    drain_all();

    // Empty FIFO with rd_en held while the first word is pushed
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'($urandom_range(15, 0)), 1'b1, 1'b0);
    check("empty_push_count", fifo_count, 1);
    // Continuous capture and drain together
    for (int i = 0; i < 40; i++) cycle(1'b1, 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'b0);
    drain_all();

    // Reset mid-word and mid-drain, then capture one word from a clean state
    for (int i = 0; i < 19; i++) cycle(1'b1, 4'($urandom_range(15, 0)), 1'b0, 1'b0);
    #2;
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i + 8), 1'b0, 1'b0);
    check("post_rst_word", rd_data, 32'hFEDC_BA98);
    drain_all();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/unison_readout_capture.md
Name: unison_readout_capture

Overview:
- Downstream consumer of one digital_unison instance's logic-analyzer readout lanes (read_out_I[1:0], read_out_Q[1:0]).
- Samples both 2-bit lanes every clk_master cycle while capture is enabled and packs them into WORD_W-bit words.
- Buffers words in a first-word-fall-through FIFO so firmware can drain results at LA/host pace without losing data.
- Reports buffer fill level and a sticky overflow flag.

Parameters:
- WORD_W, 32, packed word width. Must be a multiple of 4 and ≥8. NIB = WORD_W/4 samples per word.
- DEPTH, 8, FIFO depth in words. Must be a power of 2 and ≥2. AW = $clog2(DEPTH).

Ports:
- clk_master  in  1  sole clock, rising edge; same clock that drives the digital_unison instance
- rstb  in  1  asynchronous active-low reset
- cap_en  in  1  level capture enable
- read_out_I  in  2  I-lane readout from digital_unison
- read_out_Q  in  2  Q-lane readout from digital_unison
- rd_en  in  1  pop request
- rd_data  out  WORD_W  FIFO head word
- rd_valid  out  1  FIFO non-empty; rd_data valid
- fifo_count  out  AW+1  words currently stored, 0..DEPTH
- overflow  out  1  sticky; a completed word was dropped
- clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (rstb=0, async assert, sync-to-edge release): pack counter=0, shift register=0, write/read pointers=0, fifo_count=0, rd_valid=0, overflow=0. rd_data drives 0 while rd_valid=0. FIFO RAM contents are don't-care.
- Sample: each rising edge with cap_en=1, nib = {read_out_I, read_out_Q}. read_out_I occupies nib[3:2].
- Packing is LSB-first. Sample k (k=0..NIB-1) of a word lands in bits [4k+3:4k].
- Pack counter runs 0..NIB-1 and wraps to 0 after sample NIB-1.
- On the edge that samples nibble NIB-1, the complete word (including that nibble) is pushed. There are no bubbles: capture continues next cycle into a new word.
- cap_en=0: no sampling. Pack counter and shift register clear to 0, so any partial word is discarded. Re-enabling always starts at nibble 0.
- FIFO is first-word-fall-through. A word pushed at edge N appears on rd_data with rd_valid=1 after edge N (0-cycle read latency when the FIFO was empty).
- Pop: on an edge with rd_en=1 and rd_valid=1, the head advances. With rd_en=1 and rd_valid=0 nothing happens; this is not an error.
- fifo_count = pushes − pops, updated at the same edge as the push/pop.
- Full FIFO, push without pop: the word is dropped, pointers and count are unchanged, overflow is set to 1.
- Full FIFO, push with pop in the same edge: both succeed, count stays DEPTH, no overflow.
- Empty FIFO, push with rd_en in the same edge: push succeeds, pop is ignored, count becomes 1.
- Pointers are AW bits and wrap modulo DEPTH. Full/empty are derived from fifo_count.
- overflow stays set until clr_ovf=1 at an edge. If clr_ovf and a new overflow occur on the same edge, set wins.
- Reset asserted mid-word or mid-drain: all state is cleared immediately and the partial word is lost.

Optional Feature:
- Macro: READOUT_PARITY_EN.
- Defined: adds output port rd_parity (1 bit). It equals the XOR of all WORD_W bits of the word, computed at push and stored alongside the word in the FIFO (RAM width WORD_W+1). It travels with rd_data and reads 0 when rd_valid=0.
- Undefined: the port and the extra storage bit do not exist. All other behaviour is identical.

Test Plan:
- Reset/idle: assert rstb=0 mid-operation → rd_valid=0, rd_data=0, fifo_count=0, overflow=0. After release with cap_en=0 for 20 cycles, nothing changes.
- Packing order (WORD_W=32): cap_en=1 for 8 cycles with {I,Q}=0x1,0x2,…,0x8 → after the 8th edge rd_valid=1, rd_data=0x87654321, fifo_count=1.
- Partial discard: cap_en=1 for 5 cycles, 0 for 1 cycle, then 8 cycles of nibble 0xF → exactly one word 0xFFFFFFFF is pushed, fifo_count=1.
- Overflow (DEPTH=8): capture 72 cycles continuously with rd_en=0 → fifo_count=8, overflow=1, popped words are the first 8 in order. Then clr_ovf=1 → overflow=0.
- Full with simultaneous push/pop: fill to 8, hold rd_en=1 during the cycle of the 9th push → fifo_count stays 8, overflow=0, read sequence has no gaps.
- Parity (macro defined): word 0x00000001 → rd_parity=1; word 0x00000003 → rd_parity=0.
